uart_rx_edge_bit_cnt_p: RTL
===========================

Name: uart_rx_edge_bit_cnt_p

Overview:
Parametrised edge/bit counter for the UART receiver datapath. It is the successor to the fixed-width edge/bit counter. Inputs add a runtime oversampling prescale and a runtime frame length; outputs add per-bit and per-frame completion pulses and mid-bit sample strobes for 3-sample majority voting. It sits between the RX FSM (which drives enable) and the data sampler and deserializer.

Parameters:
PRESCALE_W, 6, width of prescale and edge_cnt; legal prescale range is 4 to 2^PRESCALE_W-1.
BIT_CNT_W, 4, width of frame_bits and bit_cnt; legal frame_bits range is 2 to 2^BIT_CNT_W-1.

Ports:
clk  input  1  system clock; all logic acts on the rising edge.
rst  input  1  synchronous reset, active-low.
enable  input  1  count request from the RX FSM.
prescale  input  PRESCALE_W  oversampling edges per bit (8, 16 or 32 typical).
frame_bits  input  BIT_CNT_W  total bits per frame: start + data + parity + stop.
edge_cnt  output  PRESCALE_W  edge index within the current bit.
bit_cnt  output  BIT_CNT_W  bit index within the current frame.
busy  output  1  high while in RUN.
sample_en  output  1  high on the three mid-bit sample edges.
sample_last  output  1  high on the last of the three sample edges.
bit_done  output  1  one-cycle pulse on the final edge of each bit.
frame_done  output  1  one-cycle pulse on the final edge of the final bit.
cfg_err  output  1  sticky flag: an illegal configuration was presented at start.

Behaviour:
- Reset: when rst=0 at a clock edge, the block enters IDLE and sets edge_cnt=0, bit_cnt=0, cfg_err=0. All pulses are 0. rst overrides every other input.
- Configuration latch: registers p_q and fb_q are loaded from prescale and frame_bits only on the IDLE->RUN transition. Input changes while in RUN are ignored.
- Midpoint: mid = p_q >> 1 (floor for odd prescale).
- States are IDLE and RUN. busy = (state == RUN).
- IDLE:
  - Counters are held at 0.
  - If enable=1 and both prescale >= 4 and frame_bits >= 2: latch the configuration, clear cfg_err, go to RUN.
  - If enable=1 and the configuration is illegal: set cfg_err=1 and stay in IDLE.
- RUN with enable=1:
  - If edge_cnt != p_q-1: edge_cnt increments.
  - Else edge_cnt returns to 0.
    - If bit_cnt != fb_q-1: bit_cnt increments.
    - Else bit_cnt returns to 0 and the block stays in RUN. The next frame counts immediately, with no idle cycle between back-to-back frames.
- RUN with enable=0: next cycle goes to IDLE with both counters at 0. No frame_done is generated.
- Timing: the first RUN cycle shows edge_cnt=0, bit_cnt=0. Each bit occupies exactly p_q RUN cycles; each frame occupies exactly p_q*fb_q RUN cycles.
- Decoded outputs are combinational from the registered state and counters, and are valid in the same cycle as the count value:
  - sample_en = RUN & enable & (edge_cnt is mid-1, mid or mid+1).
  - sample_last = RUN & enable & (edge_cnt == mid+1).
  - bit_done = RUN & enable & (edge_cnt == p_q-1).
  - frame_done = bit_done & (bit_cnt == fb_q-1).
- Simultaneous events: if enable falls in the same cycle as the last edge of the frame, the deassertion wins. frame_done and bit_done stay 0 and the counters clear.
- Reset mid-frame: counters clear on the next edge, no pulses are generated, and the latched configuration is discarded.
- All arithmetic is unsigned. Counters never exceed p_q-1 or fb_q-1, so there is no overflow.

Test Plan:
1. rst=0 for 2 cycles, then rst=1 with enable=0 -> edge_cnt=0, bit_cnt=0, busy=0, cfg_err=0, all pulses 0.
2. prescale=8, frame_bits=10, enable rises and stays high -> first RUN cycle shows 0/0. sample_en on edges 3, 4, 5 and sample_last on edge 5. bit_done every 8 cycles at edge 7. frame_done once, at bit 9 edge 7 (80th RUN cycle). The next cycle shows 0/0 with busy=1.
3. prescale=16, frame_bits=11 -> sample_en on edges 7, 8, 9. frame_done on the 176th RUN cycle. Changing prescale to 8 mid-frame has no effect.
4. prescale=8, enable dropped at bit 3 edge 5 -> next cycle edge_cnt=0, bit_cnt=0, busy=0, no frame_done. Also check enable dropping exactly at bit 9 edge 7: no frame_done is produced.
5. prescale=2, frame_bits=10, enable=1 -> cfg_err=1 and busy stays 0. Then prescale=8 -> cfg_err clears and RUN starts.
6. rst=0 asserted at bit 4 edge 2 -> next cycle 0/0, IDLE, no pulses. After rst=1 with enable=1, counting restarts from 0/0.

Source files
------------

// File: rtl/uart_rx_edge_bit_cnt_p.sv
// Edge/bit counter for the UART receiver with a runtime prescale and frame length.
// It also decodes the per-bit and per-frame completion pulses and the mid-bit sample strobes.
module uart_rx_edge_bit_cnt_p #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [BIT_CNT_W-1:0]  frame_bits,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  busy,
    output logic                  sample_en,
    output logic                  sample_last,
    output logic                  bit_done,
    output logic                  frame_done,
    output logic                  cfg_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [PRESCALE_W-1:0] P_ONE   = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] P_MIN   = PRESCALE_W'(4);
    localparam logic [BIT_CNT_W-1:0]  B_ONE   = BIT_CNT_W'(1);
    localparam logic [BIT_CNT_W-1:0]  FB_MIN  = BIT_CNT_W'(2);

    state_t                  state;
    logic [PRESCALE_W-1:0]   p_q;
    logic [BIT_CNT_W-1:0]    fb_q;
    logic [PRESCALE_W-1:0]   mid;
    logic                    cfg_ok;
    logic                    last_edge;
    logic                    last_bit;
    logic                    active;

    assign cfg_ok    = (prescale >= P_MIN) && (frame_bits >= FB_MIN);
    assign mid       = p_q >> 1;
    assign last_edge = (edge_cnt == p_q - P_ONE);
    assign last_bit  = (bit_cnt == fb_q - B_ONE);

    // Reset also masks the strobes so a reset cycle never emits a pulse.
    assign active      = (state == RUN) && enable && rst;
    assign busy        = (state == RUN);
    assign sample_en   = active && ((edge_cnt == mid - P_ONE) || (edge_cnt == mid) ||
                                    (edge_cnt == mid + P_ONE));
    assign sample_last = active && (edge_cnt == mid + P_ONE);
    assign bit_done    = active && last_edge;
    assign frame_done  = bit_done && last_bit;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // here sees the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            edge_cnt <= '0;
            bit_cnt  <= '0;
            p_q      <= '0;
            fb_q     <= '0;
            cfg_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    edge_cnt <= '0;
                    bit_cnt  <= '0;
                    if (enable) begin
                        if (cfg_ok) begin
                            p_q     <= prescale;
                            fb_q    <= frame_bits;
                            cfg_err <= 1'b0;
                            state   <= RUN;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state    <= IDLE;
                        edge_cnt <= '0;
                        bit_cnt  <= '0;
                    end else if (last_edge) begin
                        // Wrapping bit_cnt keeps RUN, so back-to-back frames have no gap.
                        edge_cnt <= '0;
                        bit_cnt  <= last_bit ? '0 : bit_cnt + B_ONE;
                    end else begin
                        edge_cnt <= edge_cnt + P_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
